// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its sck generator.
package spi_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BIT_CNT_W  = $clog2(DATA_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } spi_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_sck_gen.sv
// Half-period counter producing sck (CPOL=0) plus strobes marking the edge about to happen.
module sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);

  logic [HP_W-1:0] hp_q, hp_d;
  logic            sck_q, sck_d;
  logic            term;

  // Strobes are asserted in the cycle whose closing edge toggles sck.
  always_comb begin
    term  = run && (hp_q == HP_LAST);
    hp_d  = '0;
    sck_d = 1'b0;
    if (run) begin
      hp_d  = term ? '0 : hp_q + 1'b1;
      sck_d = term ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hp_q  <= '0;
      sck_q <= 1'b0;
    end else begin
      hp_q  <= hp_d;
      sck_q <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign rise_stb = term && !sck_q;
  assign fall_stb = term && sck_q;

endmodule

// File: rtl/spi_master.sv
// SPI master (CPOL=0, CPHA=0): one DATA_W-bit MSB-first exchange per accepted start.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              sdo,
  input  logic              sdi
);

  localparam int CNT_W    = (DATA_W == DATA_W_DEF) ? BIT_CNT_W : cnt_w(DATA_W);
  localparam int GAP_W    = cnt_w(GAP_CYC);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_q, done_d;
  logic              run, rise_stb, fall_stb, last_bit;

  assign run      = (state_q == LOW) || (state_q == HIGH);
  assign last_bit = (bit_q == CNT_W'(DATA_W - 1));

  sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // tx shifts with zero fill, so sdo settles back to 0 after the final bit.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d = tx_data;
          bit_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise_stb) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], sdi};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall_stb) begin
          tx_sr_d = tx_sr_q << 1;
          if (last_bit) begin
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
            gap_d     = '0;
            state_d   = (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = IDLE;
        else                           gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign sdo     = tx_sr_q[DATA_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench: behavioural SPI slaves, expected frames queued at start, checked at done.
module tb_spi_master;

  localparam int DW    = 32;
  localparam int CD    = 4;
  localparam int GC    = 2;
  localparam int FRAME = 2 * CD * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, start1;
  logic [DW-1:0] tx_data, tx_data1;
  logic [DW-1:0] rx_data, rx_data1;
  logic          busy, busy1, done, done1, sck, sck1, sdo, sdo1, sdi, sdi1;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int nfr = 0;

  typedef struct {
    logic [DW-1:0] rx;
    logic [DW-1:0] q;
    int            cyc;
    int            rises;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.DATA_W(DW), .CLK_DIV(CD), .GAP_CYC(GC)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sck(sck), .sdo(sdo), .sdi(sdi)
  );

  spi_master #(.DATA_W(DW), .CLK_DIV(1), .GAP_CYC(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx_data1), .rx_data(rx_data1),
    .busy(busy1), .done(done1), .sck(sck1), .sdo(sdo1), .sdi(sdi1)
  );

  // Slave model: samples sdo on rising sck, presents the next bit after falling sck.
  logic [DW-1:0] sl_d, sl_sr, sl_q, sl_sh;
  int            sl_cnt, sl_rises;
  assign sl_sh = sl_d << sl_cnt;
  assign sdi   = sl_sh[DW-1];

  always @(posedge sck or negedge reset)
    if (!reset) begin sl_sr <= '0; sl_rises <= 0; end
    else begin sl_sr <= {sl_sr[DW-2:0], sdo}; sl_rises <= sl_rises + 1; end

  always @(negedge sck or negedge reset)
    if (!reset) begin sl_cnt <= 0; sl_q <= '0; end
    else if (sl_cnt == DW - 1) begin sl_cnt <= 0; sl_q <= sl_sr; end
    else sl_cnt <= sl_cnt + 1;

  logic [DW-1:0] sl1_d, sl1_sr, sl1_q, sl1_sh;
  int            sl1_cnt, sl1_rises;
  assign sl1_sh = sl1_d << sl1_cnt;
  assign sdi1   = sl1_sh[DW-1];

  always @(posedge sck1 or negedge reset)
    if (!reset) begin sl1_sr <= '0; sl1_rises <= 0; end
    else begin sl1_sr <= {sl1_sr[DW-2:0], sdo1}; sl1_rises <= sl1_rises + 1; end

  always @(negedge sck1 or negedge reset)
    if (!reset) begin sl1_cnt <= 0; sl1_q <= '0; end
    else if (sl1_cnt == DW - 1) begin sl1_cnt <= 0; sl1_q <= sl1_sr; end
    else sl1_cnt <= sl1_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: every done must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data", rx_data, mon_e.rx);
        chk("slave_q", sl_q, mon_e.q);
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("sck_rises", 32'(sl_rises), 32'(mon_e.rises));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [DW-1:0] tx, input logic [DW-1:0] d);
    wait_idle();
    sl_d    = d;
    tx_data = tx;
    start   = 1'b1;
    nfr++;
    sb.push_back('{rx: d, q: tx, cyc: cyc + 1 + FRAME, rises: nfr * DW});
    @(negedge clk);
    start   = 1'b0;
    tx_data = $urandom;
  endtask

  initial begin
    int            t0, n;
    logic [3:0]    seen;
    logic          rx_chg;
    logic [DW-1:0] rx_hold, d, tx1v;

    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    tx_data = '0; tx_data1 = '0; sl_d = '0; sl1_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    reset = 1'b1;

    send(32'hA5A5_0F0F, 32'h0000_0123);
    drain();

    // start during an active frame must be ignored
    send(32'h1357_9BDF, 32'h2468_ACE0);
    repeat (9) @(negedge clk);
    tx_data = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held: back-to-back frames spaced by the gap
    wait_idle();
    d = $urandom;
    sl_d = d; tx_data = 32'h1; start = 1'b1;
    t0 = cyc + 1;
    nfr += 2;
    sb.push_back('{rx: d, q: 32'h1, cyc: t0 + FRAME, rises: (nfr - 1) * DW});
    sb.push_back('{rx: d, q: 32'h2, cyc: t0 + FRAME + GC + 1 + FRAME, rises: nfr * DW});
    @(negedge clk);
    tx_data = 32'h2;
    while (cyc < t0 + FRAME) @(negedge clk);
    for (int i = 0; i <= GC; i++) begin
      chk("gap_sck_low", 32'(sck), 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // reset in the middle of bit 17
    send($urandom, $urandom);
    n = 0;
    while (sl_cnt != 17 && n < 1000) begin @(negedge clk); n++; end
    reset = 1'b0;
    #1;
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_sdo", 32'(sdo), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rx_data", rx_data, 32'd0);
    sb.delete();
    nfr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    send(32'hDEAD_BEEF, $urandom);
    drain();

    send(32'hFFFF_FFFF, 32'h0000_0000);
    send(32'h0000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send($urandom, $urandom);
    end
    drain();

    // CLK_DIV=1 instance: sck toggles every cycle, edge bits of the slave word
    wait_idle();
    sl1_d = 32'h8000_0001;
    tx1v = $urandom;
    tx_data1 = tx1v; start1 = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("div1_done_cycle", 32'(cyc), 32'(t0 + 2 * DW));
    chk("div1_rx_data", rx_data1, 32'h8000_0001);
    chk("div1_slave_q", sl1_q, tx1v);
    chk("div1_sck_rises", 32'(sl1_rises), 32'(DW));

    // long idle with no start
    wait_idle();
    rx_hold = rx_data; seen = '0; rx_chg = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      seen = seen | {sck, sdo, busy, done};
      if (rx_data !== rx_hold) rx_chg = 1'b1;
    end
    chk("idle_sck", 32'(seen[3]), 32'd0);
    chk("idle_sdo", 32'(seen[2]), 32'd0);
    chk("idle_busy", 32'(seen[1]), 32'd0);
    chk("idle_done", 32'(seen[0]), 32'd0);
    chk("idle_rx_hold", 32'(rx_chg), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Clock-domain SPI master that drives the board-side SPI slave interface (slave samples sdo on rising sck and shifts sdi on falling sck).
- Sends one DATA_W-bit word MSB-first on sdo and simultaneously captures one DATA_W-bit word from sdi.
- Used for bench loopback of the slave and for FPGA-to-FPGA links.
- Exactly DATA_W sck pulses per frame, so the slave's 5-bit frame counter stays aligned.

Parameters:
- DATA_W, 32: frame length in bits. Must match the slave.
- CLK_DIV, 4: sck half-period in clk cycles. Must be ≥1.
- GAP_CYC, 2: minimum idle clk cycles after done before the next start is accepted. Must be ≥0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a frame. Sampled only in IDLE.
- tx_data  in  DATA_W  word to send. Captured on start acceptance.
- rx_data  out  DATA_W  last received word. Updated only at done.
- busy  out  1  high from the cycle after start acceptance through the end of GAP.
- done  out  1  one-cycle pulse when rx_data is updated.
- sck  out  1  SPI clock. Idles low (CPOL=0, CPHA=0).
- sdo  out  1  master-out serial data.
- sdi  in  1  master-in serial data.

Behaviour:
- Reset (reset=0, asynchronous): sck=0, sdo=0, busy=0, done=0, rx_data=0, all counters=0, state=IDLE.
- States:
  - IDLE: start=1 → load tx shift register with tx_data, sdo=tx_data[DATA_W-1], bit counter=0, half-period counter=0 → LOW.
  - LOW: sck=0. After CLK_DIV cycles, raise sck and sample sdi into the LSB of the rx shift register on the same clk edge → HIGH.
  - HIGH: sck=1. After CLK_DIV cycles, drop sck.
    - If bit counter=DATA_W-1: rx_data <= rx shift register contents (all DATA_W bits), done=1 for one cycle → GAP.
    - Otherwise: shift tx left, sdo=next bit, bit counter+1 → LOW.
  - GAP: busy stays 1. After GAP_CYC cycles → IDLE (busy=0). GAP_CYC=0 returns to IDLE the next cycle.
- Timing (start sampled at edge t0):
  - first sck rise at t0+CLK_DIV;
  - last sck fall and done at t0+2·CLK_DIV·DATA_W (256 cycles at defaults);
  - next acceptance earliest at t0+2·CLK_DIV·DATA_W+GAP_CYC+1.
- sdo changes only on clk edges that drop sck, or at acceptance. It is stable ≥CLK_DIV cycles around each rise.
- sdi needs no synchronizer. The slave changes it on falling sck, CLK_DIV cycles before the sampling point.
- start while busy: ignored, with no queueing. start held high continuously: a new frame begins each time IDLE is entered.
- tx_data changes after acceptance: no effect on the current frame.
- Reset mid-frame: frame abandoned, outputs return to reset values, no done. The slave shares reset so its counter re-aligns.
- done and the final sck fall occur on the same edge. rx_data is valid in the cycle where done=1 and holds until the next done.

Decomposition:
- Package spi_pkg:
  - DATA_W default constant;
  - state enum {IDLE, LOW, HIGH, GAP} (2-bit);
  - bit-counter width constant $clog2(DATA_W).
- Sub-module sck_gen: half-period counter.
  - Inputs: clk, reset, run.
  - Outputs: sck, rise_stb, fall_stb (one-cycle strobes).
  - spi_master consumes the strobes for sampling and shifting.

Test Plan:
- Loopback with behavioural slave model (d=32'h0000_0123), tx_data=32'hA5A5_0F0F, CLK_DIV=4 → slave q=32'hA5A5_0F0F, rx_data=32'h0000_0123, done at exactly cycle 256, exactly 32 sck rises.
- start pulsed at cycle 10 of an active frame with tx_data=32'hFFFF_FFFF → ignored, current frame unaffected, only one done.
- start held high, GAP_CYC=2, two frames 32'h1, 32'h2 → done pulses 259 cycles apart, slave receives both, sck low throughout the gaps.
- reset deasserted→asserted at bit 17 → sck=0, sdo=0, busy=0 same cycle, no done. Next frame 32'hDEAD_BEEF received intact by the slave.
- CLK_DIV=1, DATA_W=32 → sck toggles every cycle, done at cycle 64, rx_data correct for slave d=32'h8000_0001 (MSB and LSB edge bits).
- Idle check: no start for 1000 cycles → sck, sdo, busy, done all 0, rx_data unchanged.
